framebuffer_dual: RTL

//   Double-buffered pixel store directly downstream of the GPU.
//   - Accepts pixel writes on the GPU framebuffer interface (fb_x/fb_y/fb_color/fb_write) into the back bank.
//   - Serves the display scanout from the front bank.
//   - Swaps banks on the first vsync edge after a swap request, so a frame becomes visible whole, without tearing.

---
 rtl/framebuffer_dual.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/framebuffer_dual.sv
// framebuffer_dual
//   Double-buffered pixel store between the GPU and the display scanout.
//   The GPU draws into the back bank while the display reads the front
//   bank. A swap request is held until the next vsync rising edge, so a
//   finished frame is shown whole, with no tearing.
//
// Ports
//   clk          single clock for all logic
//   reset        asynchronous, active-high reset
//   fb_x, fb_y   GPU write coordinate
//   fb_color     GPU write color, stored as-is
//   fb_write     GPU write strobe, one pixel per cycle
//   swap_req     swap request level; its rising edge counts
//   vsync        display vertical sync level; its rising edge counts
//   rd_x, rd_y   scanout read coordinate
//   rd_en        scanout read strobe
//   rd_data      front-bank pixel, one cycle after rd_en
//   rd_valid     rd_data carries a fresh read result
//   swap_pending swap requested, waiting for vsync
//   front_sel    bank currently displayed
//   frame_count  number of completed swaps, wraps at 256
module framebuffer_dual #(
  parameter  int FB_WIDTH  = 400,
  parameter  int FB_HEIGHT = 240,
  localparam int XW        = $clog2(FB_WIDTH) + 1,
  localparam int YW        = $clog2(FB_HEIGHT) + 1,
  localparam int AW        = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] fb_x,
  input  logic [YW-1:0] fb_y,
  input  logic [15:0]   fb_color,
  input  logic          fb_write,
  input  logic          swap_req,
  input  logic          vsync,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic          rd_valid,
  output logic          swap_pending,
  output logic          front_sel,
  output logic [7:0]    frame_count
);

  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;

  swap_state_t state_q, state_d;
  logic        front_q, front_d;
  logic [7:0]  count_q, count_d;
  logic        swap_req_q, vsync_q;
  logic        swap_rise, vs_rise;

  logic [15:0] bank0 [0:DEPTH-1];
  logic [15:0] bank1 [0:DEPTH-1];

  logic          wr_ok, rd_in_range;
  logic [AW-1:0] wr_addr, rd_addr;

  assign swap_rise = swap_req & ~swap_req_q;
  assign vs_rise   = vsync & ~vsync_q;

  // The address products can exceed the array only when the coordinate is
  // out of range, and those accesses are gated off by the range checks.
  assign wr_ok       = fb_write && (fb_x < XW'(FB_WIDTH)) && (fb_y < YW'(FB_HEIGHT));
  assign rd_in_range = (rd_x < XW'(FB_WIDTH)) && (rd_y < YW'(FB_HEIGHT));
  assign wr_addr     = AW'(fb_y) * AW'(FB_WIDTH) + AW'(fb_x);
  assign rd_addr     = AW'(rd_y) * AW'(FB_WIDTH) + AW'(rd_x);

  assign swap_pending = (state_q == PENDING);
  assign front_sel    = front_q;
  assign frame_count  = count_q;

  // Swap FSM state, bank select, frame counter and edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      count_q    <= 8'd0;
      swap_req_q <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      front_q    <= front_d;
      count_q    <= count_d;
      swap_req_q <= swap_req;
      vsync_q    <= vsync;
    end
  end

  // A vsync edge only matters once a swap is pending, so a swap request and
  // vsync rising together just arm the swap for the following vsync.
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (swap_rise) state_d = PENDING;
      end
      PENDING: begin
        if (vs_rise) begin
          state_d = IDLE;
          front_d = ~front_q;
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel writes go to the back bank; front_q is the registered select, so
  // a write in the swap cycle still lands in the pre-toggle back bank.
  always_ff @(posedge clk) begin
    if (wr_ok && front_q)  bank0[wr_addr] <= fb_color;
    if (wr_ok && !front_q) bank1[wr_addr] <= fb_color;
  end

  // Scanout reads come from the front bank only. rd_data holds between
  // reads; out-of-range reads still complete, returning black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= 16'h0000;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (!rd_in_range) rd_data <= 16'h0000;
        else if (front_q) rd_data <= bank1[rd_addr];
        else              rd_data <= bank0[rd_addr];
      end
    end
  end

endmodule
